vga_timing: RTL

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 103 ++++++++++
 1 files changed

// File: rtl/vga_timing.sv
// VGA raster timing generator.
// Walks a pixel counter (hc) and a line counter (vc) across the full frame,
// one step per pixel-rate enable, and produces registered sync, blanking and
// line/frame start strobes that line up with the counters being driven.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       pix_en,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  // Next raster position; the >= compares pull any out-of-range value back to 0.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_en) begin
      if (hc_q >= H_LAST) begin
        hc_d = '0;
        if (vc_q >= V_LAST) begin
          vc_d = '0;
        end else begin
          vc_d = vc_q + 10'd1;
        end
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  // Decode sync/blank/strobes from the next position so they register alongside it.
  always_comb begin
    hsync_d       = !((hc_d >= HS_START) && (hc_d < HS_END));
    vsync_d       = !((vc_d >= VS_START) && (vc_d < VS_END));
    video_on_d    = (hc_d < H_VIS) && (vc_d < V_VIS);
    line_start_d  = pix_en && (hc_d == '0);
    frame_start_d = line_start_d && (vc_d == '0);
  end

  // State register; reset parks on the last pixel so the first enable starts a frame.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hc_q          <= H_LAST;
      vc_q          <= V_LAST;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hc          = hc_q;
  assign vc          = vc_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
